// File: rtl/tdc_gpx_bus_engine.sv
// ==== tdc_gpx_bus_engine : burst-capable TDC-GPX parallel bus engine (rev 1.0) ====
`default_nettype none

module tdc_gpx_bus_engine #(
  parameter int DATA_W     = 28,
  parameter int ADDR_W     = 4,
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1,
  parameter int LEN_W      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_read,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              abort,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_last,
  output logic              done,
  output logic [LEN_W-1:0]  done_count,
  output logic              ef_stop,
  input  logic              tdc_ef,
  inout  wire  [DATA_W-1:0] tdc_d,
  output logic [ADDR_W-1:0] tdc_addr,
  output logic              tdc_csn,
  output logic              tdc_wrn,
  output logic              tdc_rdn,
  output logic              tdc_oen
);

  localparam int MAX_SH  = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
  localparam int MAX_CYC = (STROBE_CYC > MAX_SH) ? STROBE_CYC : MAX_SH;
  localparam int CYC_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CYC_W-1:0] SETUP_LAST  = CYC_W'(SETUP_CYC - 1);
  localparam logic [CYC_W-1:0] STROBE_LAST = CYC_W'(STROBE_CYC - 1);
  localparam logic [CYC_W-1:0] HOLD_LAST   = CYC_W'(HOLD_CYC - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t              state, state_n;
  logic [CYC_W-1:0]    cyc, cyc_n;
  logic [LEN_W-1:0]    remaining, remaining_n;
  logic [LEN_W-1:0]    words, words_n;
  logic                is_read;
  logic [DATA_W-1:0]   wdata_q;
  logic                abort_seen;
  logic                ef_meta, ef_sync;
  logic                drive;
  logic                accept, read_next;
  logic                capture, finish, ef_hit;

  assign accept    = (state == IDLE) && cmd_valid;
  assign read_next = accept ? cmd_read : is_read;
  assign tdc_d     = drive ? wdata_q : {DATA_W{1'bz}};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ef_meta <= 1'b0;
      ef_sync <= 1'b0;
    end else begin
      ef_meta <= tdc_ef;
      ef_sync <= ef_meta;
    end
  end

  always_comb begin
    state_n     = state;
    cyc_n       = cyc;
    remaining_n = remaining;
    words_n     = words;
    capture     = 1'b0;
    finish      = 1'b0;
    ef_hit      = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          state_n     = SETUP;
          cyc_n       = '0;
          words_n     = '0;
          remaining_n = (cmd_read && (cmd_len != '0)) ? cmd_len : LEN_W'(1);
        end
      end
      SETUP: begin
        if (cyc == SETUP_LAST) begin
          cyc_n = '0;
          // An empty FIFO aborts the word before any strobe is issued.
          if (is_read && ef_sync) begin
            state_n = IDLE;
            finish  = 1'b1;
            ef_hit  = 1'b1;
          end else begin
            state_n = STROBE;
          end
        end else begin
          cyc_n = cyc + 1'b1;
        end
      end
      STROBE: begin
        if (cyc == STROBE_LAST) begin
          cyc_n   = '0;
          state_n = HOLD;
          capture = is_read;
        end else begin
          cyc_n = cyc + 1'b1;
        end
      end
      HOLD: begin
        if (cyc == HOLD_LAST) begin
          cyc_n       = '0;
          remaining_n = remaining - 1'b1;
          words_n     = words + 1'b1;
          if (is_read && (remaining > LEN_W'(1)) && !abort_seen && !abort) begin
            state_n = SETUP;
          end else begin
            state_n = IDLE;
            finish  = 1'b1;
          end
        end else begin
          cyc_n = cyc + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Pin-facing outputs are registered from the next state so they change on the edge that enters each state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cyc        <= '0;
      remaining  <= '0;
      words      <= '0;
      is_read    <= 1'b0;
      wdata_q    <= '0;
      abort_seen <= 1'b0;
      cmd_ready  <= 1'b1;
      tdc_addr   <= '0;
      tdc_csn    <= 1'b1;
      tdc_wrn    <= 1'b1;
      tdc_rdn    <= 1'b1;
      tdc_oen    <= 1'b1;
      drive      <= 1'b0;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
      rd_last    <= 1'b0;
      done       <= 1'b0;
      done_count <= '0;
      ef_stop    <= 1'b0;
    end else begin
      state      <= state_n;
      cyc        <= cyc_n;
      remaining  <= remaining_n;
      words      <= words_n;
      abort_seen <= (state == IDLE) ? 1'b0 : (abort_seen | abort);
      if (accept) begin
        is_read  <= cmd_read;
        wdata_q  <= cmd_wdata;
        tdc_addr <= cmd_addr;
      end
      cmd_ready <= (state_n == IDLE);
      tdc_csn   <= !(state_n == STROBE);
      tdc_wrn   <= !((state_n == STROBE) && !read_next);
      tdc_rdn   <= !((state_n == STROBE) && read_next);
      tdc_oen   <= !((state_n == STROBE) && read_next);
      drive     <= (state_n != IDLE) && !read_next;
      if (capture) begin
        rd_data <= tdc_d;
      end
      rd_valid <= capture;
      rd_last  <= capture && (remaining == LEN_W'(1));
      done     <= finish;
      ef_stop  <= ef_hit;
      if (finish) begin
        done_count <= words_n;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tdc_gpx_bus_engine.sv
// Randomized self-checking bench for tdc_gpx_bus_engine: default instance plus a SETUP=2/STROBE=3/HOLD=2 instance.
`default_nettype none

module tb_tdc_gpx_bus_engine;
  localparam int DW = 28;
  localparam int AW = 4;
  localparam int LW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, sel;
  logic          cmd_valid, cmd_read, abort;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [LW-1:0] cmd_len;
  logic [DW-1:0] mem [16];
  logic [DW-1:0] tdc_word;
  int            rd_ptr, depth;
  logic          tdc_ef;
  assign tdc_ef = (rd_ptr >= depth);

  logic cmd_valid_a, cmd_valid_b;
  assign cmd_valid_a = cmd_valid && !sel;
  assign cmd_valid_b = cmd_valid && sel;

  logic          cmd_ready_a, rd_valid_a, rd_last_a, done_a, ef_stop_a, csn_a, wrn_a, rdn_a, oen_a;
  logic          cmd_ready_b, rd_valid_b, rd_last_b, done_b, ef_stop_b, csn_b, wrn_b, rdn_b, oen_b;
  logic [DW-1:0] rd_data_a, rd_data_b;
  logic [LW-1:0] done_count_a, done_count_b;
  logic [AW-1:0] taddr_a, taddr_b;
  wire  [DW-1:0] tdc_d_a, tdc_d_b;
  assign tdc_d_a = rdn_a ? {DW{1'bz}} : tdc_word;
  assign tdc_d_b = rdn_b ? {DW{1'bz}} : tdc_word;

  tdc_gpx_bus_engine dut_a (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid_a), .cmd_ready(cmd_ready_a),
    .cmd_read(cmd_read), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_len(cmd_len),
    .abort(abort), .rd_data(rd_data_a), .rd_valid(rd_valid_a), .rd_last(rd_last_a),
    .done(done_a), .done_count(done_count_a), .ef_stop(ef_stop_a), .tdc_ef(tdc_ef),
    .tdc_d(tdc_d_a), .tdc_addr(taddr_a), .tdc_csn(csn_a), .tdc_wrn(wrn_a),
    .tdc_rdn(rdn_a), .tdc_oen(oen_a));

  tdc_gpx_bus_engine #(.SETUP_CYC(2), .STROBE_CYC(3), .HOLD_CYC(2)) dut_b (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b),
    .cmd_read(cmd_read), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_len(cmd_len),
    .abort(abort), .rd_data(rd_data_b), .rd_valid(rd_valid_b), .rd_last(rd_last_b),
    .done(done_b), .done_count(done_count_b), .ef_stop(ef_stop_b), .tdc_ef(tdc_ef),
    .tdc_d(tdc_d_b), .tdc_addr(taddr_b), .tdc_csn(csn_b), .tdc_wrn(wrn_b),
    .tdc_rdn(rdn_b), .tdc_oen(oen_b));

  logic          cmd_ready, rd_valid, rd_last, done, ef_stop, csn, wrn, rdn, oen;
  logic [DW-1:0] rd_data, bus;
  logic [LW-1:0] done_count;
  logic [AW-1:0] taddr;
  always_comb begin
    cmd_ready  = sel ? cmd_ready_b  : cmd_ready_a;
    rd_valid   = sel ? rd_valid_b   : rd_valid_a;
    rd_last    = sel ? rd_last_b    : rd_last_a;
    done       = sel ? done_b       : done_a;
    ef_stop    = sel ? ef_stop_b    : ef_stop_a;
    csn        = sel ? csn_b        : csn_a;
    wrn        = sel ? wrn_b        : wrn_a;
    rdn        = sel ? rdn_b        : rdn_a;
    oen        = sel ? oen_b        : oen_a;
    rd_data    = sel ? rd_data_b    : rd_data_a;
    bus        = sel ? tdc_d_b      : tdc_d_a;
    done_count = sel ? done_count_b : done_count_a;
    taddr      = sel ? taddr_b      : taddr_a;
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issues one command and checks the whole transaction cycle by cycle against timing derived
  // from the word period, the burst length, the FIFO depth and the abort point.
  task automatic run_cmd(input bit s, input bit rd, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         input int len, input int dep, input int abort_w, input int gap);
    int S, St, T, len_eff, n_words, done_c, nv, widx, m, off;
    bit efs, exp_low, exp_rv;
    int bad_low, bad_rw, bad_d, bad_a, bad_rdy, bad_rv, bad_done;
    logic prev_csn, prev_rdn;
    S  = s ? 2 : 1;
    St = s ? 3 : 2;
    T  = s ? 7 : 4;
    sel = s;
    depth = dep;
    rd_ptr = 0;
    repeat (gap) begin
      abort = ($urandom_range(0, 3) == 0);
      @(posedge clk); #1;
    end
    abort = 1'b0;
    check("ready_before", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_read = rd; cmd_addr = a; cmd_wdata = wd; cmd_len = LW'(len);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_read = 1'($urandom); cmd_addr = AW'($urandom); cmd_wdata = DW'($urandom); cmd_len = LW'($urandom);

    len_eff = rd ? ((len == 0) ? 1 : len) : 1;
    efs = 1'b0;
    if (rd && dep < len_eff && (abort_w < 0 || dep <= abort_w)) begin
      n_words = dep;
      efs = 1'b1;
    end else if (abort_w >= 0 && abort_w < len_eff - 1) begin
      n_words = abort_w + 1;
    end else begin
      n_words = len_eff;
    end
    done_c = efs ? n_words * T + S : n_words * T;

    nv = 0; widx = 0; prev_csn = 1'b1; prev_rdn = 1'b1;
    bad_low = 0; bad_rw = 0; bad_d = 0; bad_a = 0; bad_rdy = 0; bad_rv = 0; bad_done = 0;
    for (int c = 0; c <= done_c; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
      end
      exp_low = (c < n_words * T) && ((c % T) >= S) && ((c % T) < S + St);
      if (csn !== !exp_low) bad_low++;
      if (rd) begin
        if (rdn !== !exp_low || oen !== !exp_low || wrn !== 1'b1) bad_rw++;
      end else begin
        if (wrn !== !exp_low || rdn !== 1'b1 || oen !== 1'b1) bad_rw++;
        if (c < T && bus !== wd) bad_d++;
      end
      if (taddr !== a) bad_a++;
      if (cmd_ready !== (c >= done_c)) bad_rdy++;
      off = c - S - St;
      exp_rv = rd && (off >= 0) && ((off % T) == 0) && ((off / T) < n_words);
      if (rd_valid !== exp_rv) bad_rv++;
      if (exp_rv) begin
        m = off / T;
        if (rd_data !== mem[m] || rd_last !== (m == len_eff - 1)) bad_rv++;
      end
      if (rd_valid === 1'b1) nv++;
      if (done !== (c == done_c)) bad_done++;
      if (c == done_c) begin
        check("done_count", done_count, n_words);
        check("ef_stop", ef_stop, efs);
      end
      abort = 1'b0;
      if (csn == 1'b0 && prev_csn == 1'b1) begin
        if (widx == abort_w) abort = 1'b1;
        widx++;
      end
      if (rdn == 1'b0 && prev_rdn == 1'b1) begin
        tdc_word = mem[rd_ptr[3:0]];
        rd_ptr++;
      end
      prev_csn = csn;
      prev_rdn = rdn;
    end
    abort = 1'b0;
    check("strobe_csn", bad_low, 0);
    check("strobe_rw", bad_rw, 0);
    check("wr_data", bad_d, 0);
    check("addr", bad_a, 0);
    check("ready", bad_rdy, 0);
    check("rd_valid", bad_rv, 0);
    check("done", bad_done, 0);
    check("words_read", nv, rd ? n_words : 0);
  endtask

  initial begin
    int len, le, dep, aw, gap;
    bit s, rd, prev_sel;
    reset = 1'b1; sel = 1'b0; cmd_valid = 1'b0; cmd_read = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; cmd_len = '0; abort = 1'b0; depth = 16; rd_ptr = 0; tdc_word = '0;
    for (int k = 0; k < 16; k++) mem[k] = DW'($urandom);
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", cmd_ready, 1);
    check("rst_strobes", {csn, wrn, rdn, oen}, 4'hF);
    check("rst_outs", {rd_valid, rd_last, done, ef_stop, done_count, taddr, rd_data}, '0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;

    run_cmd(0, 0, 4'h9, 28'h0ABCDEF, 0, 16, -1, 3);
    mem[0] = 28'h1; mem[1] = 28'h2; mem[2] = 28'h3;
    run_cmd(0, 1, 4'h8, '0, 3, 16, -1, 3);
    run_cmd(0, 1, 4'h8, '0, 3, 2, -1, 3);
    run_cmd(0, 1, 4'h8, '0, 10, 16, 3, 3);
    run_cmd(1, 1, 4'h5, '0, 0, 16, -1, 3);
    run_cmd(0, 1, 4'h2, '0, 2, 0, -1, 3);
    run_cmd(0, 0, 4'h3, 28'h1234567, 0, 16, -1, 3);
    run_cmd(0, 0, 4'hC, 28'h7654321, 0, 16, -1, 0);

    // Reset in the middle of a read burst must release the strobes at once.
    sel = 1'b0; depth = 100; rd_ptr = 0;
    repeat (3) begin @(posedge clk); #1; end
    cmd_valid = 1'b1; cmd_read = 1'b1; cmd_addr = 4'h6; cmd_len = 8'd10;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    check("mid_strobe_low", {csn, rdn}, 2'b00);
    #2 reset = 1'b1;
    #1;
    check("async_rst_strobes", {csn, wrn, rdn, oen}, 4'hF);
    check("async_rst_ready", cmd_ready, 1);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    check("post_rst_outs", {rd_valid, rd_last, done, ef_stop, done_count, taddr, rd_data}, '0);
    check("post_rst_strobes", {cmd_ready, csn, wrn, rdn, oen}, 5'h1F);

    prev_sel = 1'b0;
    for (int i = 0; i < 40; i++) begin
      s   = 1'($urandom_range(0, 1));
      rd  = 1'($urandom_range(0, 1));
      len = $urandom_range(0, 6);
      le  = rd ? ((len == 0) ? 1 : len) : 1;
      dep = ($urandom_range(0, 2) == 0) ? $urandom_range(0, le) : 16;
      if (rd) aw = (le > 1 && $urandom_range(0, 2) == 0) ? $urandom_range(0, le - 2) : -1;
      else    aw = ($urandom_range(0, 1) == 1) ? 0 : -1;
      gap = (!rd && s == prev_sel && $urandom_range(0, 1) == 1) ? 0 : $urandom_range(3, 5);
      for (int k = 0; k < 16; k++) mem[k] = DW'($urandom);
      run_cmd(s, rd, AW'($urandom), DW'($urandom), len, dep, aw, gap);
      prev_sel = s;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tdc_gpx_bus_engine.md
# tdc_gpx_bus_engine

Parametrised, burst-capable asynchronous bus engine for the TDC-GPX parallel interface. It supersedes the fixed 4-cycle read/write controller with:
- configurable bus width and address width;
- programmable setup/strobe/hold cycle counts;
- multi-word read bursts from one address (FIFO drain), terminated by the TDC empty flag or an abort.

It sits between the acquisition controller and the TDC-GPX pins.

## Interface
- DATA_W, 28, data bus width
- ADDR_W, 4, address width
- SETUP_CYC, 1, cycles address is stable before strobe (>=1)
- STROBE_CYC, 2, cycles csn plus wrn/rdn held low (>=1)
- HOLD_CYC, 1, recovery cycles after strobe, bus turnaround (>=1)
- LEN_W, 8, burst length/count width

- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  engine idle, command accepted on cmd_valid&&cmd_ready
- cmd_read  in  1  1 = read burst, 0 = single write
- cmd_addr  in  ADDR_W  TDC register address
- cmd_wdata  in  DATA_W  write data
- cmd_len  in  LEN_W  read burst word count, 0 treated as 1, ignored for writes
- abort  in  1  stop burst at next word boundary
- rd_data  out  DATA_W  captured read word
- rd_valid  out  1  one-cycle strobe, rd_data valid
- rd_last  out  1  with rd_valid, final word of burst
- done  out  1  one-cycle pulse at command completion
- done_count  out  LEN_W  words transferred, valid with done
- ef_stop  out  1  with done, burst ended by empty flag
- tdc_ef  in  1  TDC FIFO empty flag, active-high, asynchronous to clk
- tdc_d  inout  DATA_W  bidirectional data bus
- tdc_addr  out  ADDR_W  address
- tdc_csn, tdc_wrn, tdc_rdn, tdc_oen  out  1 each  active-low strobes

## Operation
- **States:** IDLE, SETUP, STROBE, HOLD.
- **Registers:** one cycle counter, one word counter.
- **Outputs:** all registered, computed look-ahead from next state. No combinational path from inputs to pins.
- **Reset values:**
  - cmd_ready=1;
  - tdc_csn/wrn/rdn/oen=1;
  - tdc_addr=0;
  - tdc_d=Z;
  - rd_data=0;
  - rd_valid, rd_last, done, ef_stop, done_count = 0.
- **IDLE:** on acceptance:
  - latch addr, wdata, read flag;
  - remaining = max(cmd_len,1) for reads, 1 for writes;
  - go to SETUP;
  - cmd_ready drops.
- **SETUP:** tdc_addr driven, strobes high.
  - Writes drive tdc_d from SETUP through HOLD.
  - Reads leave tdc_d at Z.
- **SETUP exit (reads):** tdc_ef is passed through a 2-flop synchroniser. Its synchronised value is sampled on the last SETUP cycle. If high, skip STROBE, go to IDLE, and pulse done with ef_stop=1 and done_count = words already read.
- **STROBE:**
  - Write: tdc_csn=tdc_wrn=0.
  - Read: tdc_csn=tdc_rdn=tdc_oen=0.
  - Held for exactly STROBE_CYC cycles.
- **STROBE exit (reads):** tdc_d is captured into rd_data on the clock edge ending the last STROBE cycle, while the strobes are still low.
- **HOLD:** strobes high, address held.
  - Writes keep tdc_d driven.
  - Reads keep tdc_d at Z.
- **HOLD exit:** decrement remaining, increment done_count. Return to SETUP (same address) if all hold:
  - remaining > 0;
  - the command is a read;
  - abort has not been seen since the previous word boundary.
  Otherwise go to IDLE.
- **abort:** latched when it arrives. It never truncates a word in flight. An abort while IDLE is ignored and cleared.
- **Reset mid-operation:** strobes go high and tdc_d goes to Z immediately, asynchronously. No done pulse.

## Timing
- Acceptance at edge k. Word period T = SETUP_CYC + STROBE_CYC + HOLD_CYC.
- Word n (n=0..) occupies edges k+nT through k+(n+1)T:
  - strobes low from edge k+nT+SETUP_CYC to edge k+nT+SETUP_CYC+STROBE_CYC;
  - capture on the latter edge;
  - rd_valid high for the following cycle.
- rd_last is asserted with the rd_valid of the last word when remaining reaches 0.
  - Not asserted on abort or ef_stop; the done pulse marks the end instead.
- done and cmd_ready=1 follow edge k+NT (N = words transferred). Single write at defaults: cmd_ready low 4 cycles.
- Back-to-back commands: a new command may be accepted in the first IDLE cycle. Minimum one IDLE cycle between commands.
- cmd_* inputs are don't-care except during the acceptance cycle.

## Test plan
- **Reset:** assert reset mid-burst → all strobes 1, tdc_d=Z, cmd_ready=1 the same cycle. After release, all outputs at reset values.
- **Single write, defaults:** addr 4'h9, data 28'h0ABCDEF → tdc_wrn and tdc_csn low exactly 2 cycles, starting 1 cycle after acceptance. tdc_d=28'h0ABCDEF from SETUP through HOLD. done_count=1; cmd_ready high again 4 cycles after acceptance.
- **Read burst:** addr 4'h8, cmd_len=3, model returns 28'h1, 28'h2, 28'h3 → three rd_valid pulses 4 cycles apart with those values. rd_last on the third. done_count=3, ef_stop=0.
- **Empty-flag stop:** as above, with tdc_ef raised after the 2nd word → 2 rd_valid, no rd_last, done with done_count=2 and ef_stop=1. No third strobe.
- **Abort:** cmd_len=10, abort pulsed during the 4th word's STROBE → 4th word completes, done_count=4, no further strobes.
- **Parameter sweep:** SETUP=2, STROBE=3, HOLD=2, cmd_len=0 → exactly one read, strobe width 3 cycles, T=7, done_count=1.
